// File: rtl/bp_bht_btb_if.sv
// bp_bht_btb_if
//   Bundles the branch predictor's lookup, update and performance signals.
//   The master side is the core (IF stage for lookups, ex stage for updates);
//   the slave side is the predictor itself.
// Signals
//   hold_i         IF stage held; suppresses prediction and lookup counting
//   lookup_addr_i  fetch PC
//   lookup_inst_i  instruction fetched at lookup_addr_i
//   pred_taken_o   predict redirect
//   pred_addr_o    predicted next PC
//   upd_valid_i    ex-stage resolution strobe
//   upd_kind_i     01 conditional branch, 10 JALR, others ignored
//   upd_pc_i       PC of the resolved instruction
//   upd_taken_i    resolved direction
//   upd_target_i   resolved target
//   upd_mispred_i  ex detected a misprediction
//   perf_lookups_o count of predicted control instructions
//   perf_mispred_o count of mispredictions
interface bp_bht_btb_if #(
  parameter int ADDR_W = 32
);
  logic              hold_i;
  logic [ADDR_W-1:0] lookup_addr_i;
  logic [31:0]       lookup_inst_i;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_addr_o;
  logic              upd_valid_i;
  logic [1:0]        upd_kind_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_mispred_i;
  logic [31:0]       perf_lookups_o;
  logic [31:0]       perf_mispred_o;

  modport master (
    output hold_i, lookup_addr_i, lookup_inst_i,
    output upd_valid_i, upd_kind_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i,
    input  pred_taken_o, pred_addr_o, perf_lookups_o, perf_mispred_o
  );

  modport slave (
    input  hold_i, lookup_addr_i, lookup_inst_i,
    input  upd_valid_i, upd_kind_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i,
    output pred_taken_o, pred_addr_o, perf_lookups_o, perf_mispred_o
  );
endinterface

// File: rtl/bp_bht_btb.sv
// bp_bht_btb
//   IF-stage branch predictor. A direct-mapped table indexed by fetch PC holds,
//   per entry, a valid bit, a tag, a saturating direction counter (BHT part) and
//   a target address (BTB part, used by JALR). JAL is always predicted taken
//   from its own immediate; conditional branches use the counter MSB on a tag
//   hit; JALR uses the stored target on a tag hit. Lookup is combinational and
//   the ex stage writes one resolution per cycle.
// Ports
//   clk  core clock
//   rst  asynchronous reset, active-high
//   bus  bp_bht_btb_if slave: lookup, prediction, update and perf counters
module bp_bht_btb #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8,
  parameter int ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  bp_bht_btb_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] KIND_B    = 2'b01;
  localparam logic [1:0] KIND_JALR = 2'b10;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  logic [31:0] perf_lookups_q;
  logic [31:0] perf_mispred_q;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic [6:0]        opcode;
  logic [ADDR_W-1:0] imm_j_ext;
  logic [ADDR_W-1:0] imm_b_ext;
  logic              is_ctrl;
  logic              unused_upd_pc;

  assign lk_idx = bus.lookup_addr_i[IDX_W+1:2];
  assign lk_tag = bus.lookup_addr_i[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign up_idx = bus.upd_pc_i[IDX_W+1:2];
  assign up_tag = bus.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Only the index and tag slices of the resolved PC address the table.
  assign unused_upd_pc = ^bus.upd_pc_i;

  // RISC-V J and B immediates, sign-extended to the address width.
  assign opcode    = bus.lookup_inst_i[6:0];
  assign imm_j_ext = {{(ADDR_W-20){bus.lookup_inst_i[31]}}, bus.lookup_inst_i[19:12],
                      bus.lookup_inst_i[20], bus.lookup_inst_i[30:21], 1'b0};
  assign imm_b_ext = {{(ADDR_W-12){bus.lookup_inst_i[31]}}, bus.lookup_inst_i[7],
                      bus.lookup_inst_i[30:25], bus.lookup_inst_i[11:8], 1'b0};

  // Prediction reads the table as it stands before this cycle's update, so a
  // same-cycle update to the looked-up index becomes visible one cycle later.
  always_comb begin
    bus.pred_taken_o = 1'b0;
    bus.pred_addr_o  = '0;
    is_ctrl          = 1'b0;
    if (!bus.hold_i && !rst) begin
      case (opcode)
        OP_JAL: begin
          is_ctrl          = 1'b1;
          bus.pred_taken_o = 1'b1;
          bus.pred_addr_o  = bus.lookup_addr_i + imm_j_ext;
        end
        OP_B: begin
          is_ctrl          = 1'b1;
          bus.pred_taken_o = lk_hit && cnt_q[lk_idx][CNT_W-1];
          bus.pred_addr_o  = bus.lookup_addr_i + imm_b_ext;
        end
        OP_JALR: begin
          is_ctrl          = 1'b1;
          bus.pred_taken_o = lk_hit;
          bus.pred_addr_o  = target_q[lk_idx];
        end
        default: ;
      endcase
    end
  end

  // Table write port. A miss overwrites whatever lives at the index, so
  // aliasing PCs simply evict each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= CNT_WNT;
        target_q[i] <= '0;
      end
    end else if (bus.upd_valid_i) begin
      case (bus.upd_kind_i)
        KIND_B: begin
          if (up_hit) begin
            if (bus.upd_taken_i && (cnt_q[up_idx] != CNT_MAX)) begin
              cnt_q[up_idx] <= cnt_q[up_idx] + CNT_W'(1);
            end else if (!bus.upd_taken_i && (cnt_q[up_idx] != '0)) begin
              cnt_q[up_idx] <= cnt_q[up_idx] - CNT_W'(1);
            end
          end else begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            cnt_q[up_idx]    <= bus.upd_taken_i ? CNT_WT : CNT_WNT;
            target_q[up_idx] <= bus.upd_target_i;
          end
        end
        KIND_JALR: begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= bus.upd_target_i;
          if (!up_hit) begin
            cnt_q[up_idx] <= CNT_WT;
          end
        end
        default: ;
      endcase
    end
  end

  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lookups_q <= '0;
      perf_mispred_q <= '0;
    end else begin
      if (is_ctrl) begin
        perf_lookups_q <= perf_lookups_q + 32'd1;
      end
      if (bus.upd_valid_i && bus.upd_mispred_i) begin
        perf_mispred_q <= perf_mispred_q + 32'd1;
      end
    end
  end

  assign bus.perf_lookups_o = perf_lookups_q;
  assign bus.perf_mispred_o = perf_mispred_q;

endmodule

// File: tb/tb_bp_bht_btb.sv
// tb_bp_bht_btb
//   Directed testbench for bp_bht_btb with default parameters (16 entries,
//   2-bit counters, 8-bit tags, 32-bit addresses). Each scenario task drives
//   its own stimulus and compares against hand-computed values.
module tb_bp_bht_btb;

  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [31:0] INST_JALR = 32'h0000_8067;
  localparam logic [31:0] INST_ADDI = 32'h0104_0413;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bp_bht_btb_if #(.ADDR_W(32)) bus ();

  bp_bht_btb #(
    .ENTRIES(16),
    .CNT_W  (2),
    .TAG_W  (8),
    .ADDR_W (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  // Present an instruction on the lookup port and let the comb path settle.
  task automatic lookup(input logic [31:0] pc, input logic [31:0] inst);
    bus.lookup_addr_i = pc;
    bus.lookup_inst_i = inst;
    #1;
  endtask

  // Drive one resolution for exactly one rising edge.
  task automatic do_update(input logic [1:0] kind, input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic mispred);
    bus.upd_valid_i   = 1'b1;
    bus.upd_kind_i    = kind;
    bus.upd_pc_i      = pc;
    bus.upd_taken_i   = taken;
    bus.upd_target_i  = target;
    bus.upd_mispred_i = mispred;
    @(posedge clk);
    #1;
    bus.upd_valid_i   = 1'b0;
    bus.upd_mispred_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    lookup(32'h200, enc_j(21'h1FFFF8));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_taken: got %0b expected 0", bus.pred_taken_o);
    end
    n_checks++;
    if (bus.pred_addr_o !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_addr: got %h expected 00000000", bus.pred_addr_o);
    end
    n_checks++;
    if (bus.perf_lookups_o !== 32'h0 || bus.perf_mispred_o !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_perf: got %h/%h expected 0/0", bus.perf_lookups_o, bus.perf_mispred_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_bht_basic;
    lookup(32'h100, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bht_cold: got %0b expected 0", bus.pred_taken_o);
    end
    do_update(2'b01, 32'h100, 1'b1, 32'h110, 1'b1);
    do_update(2'b01, 32'h100, 1'b1, 32'h110, 1'b0);
    lookup(32'h100, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_addr_o !== 32'h110) begin
      n_fail++; $display("[TB] FAIL bht_trained: got %0b/%h expected 1/00000110", bus.pred_taken_o, bus.pred_addr_o);
    end
  endtask

  task automatic test_saturation;
    do_update(2'b01, 32'h100, 1'b1, 32'h110, 1'b0);
    do_update(2'b01, 32'h100, 1'b1, 32'h110, 1'b0);
    do_update(2'b01, 32'h100, 1'b0, 32'h110, 1'b0);
    lookup(32'h100, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sat_high_one_nt: got %0b expected 1", bus.pred_taken_o);
    end
    do_update(2'b01, 32'h100, 1'b0, 32'h110, 1'b0);
    lookup(32'h100, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sat_weak_nt: got %0b expected 0", bus.pred_taken_o);
    end
    do_update(2'b01, 32'h100, 1'b0, 32'h110, 1'b0);
    for (int i = 0; i < 5; i++) do_update(2'b01, 32'h100, 1'b0, 32'h110, 1'b0);
    lookup(32'h100, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sat_floor: got %0b expected 0", bus.pred_taken_o);
    end
    // From a floor of 0, one taken reaches 1 (still not taken), a second reaches 2.
    do_update(2'b01, 32'h100, 1'b1, 32'h110, 1'b0);
    lookup(32'h100, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sat_no_underflow: got %0b expected 0", bus.pred_taken_o);
    end
    do_update(2'b01, 32'h100, 1'b1, 32'h110, 1'b0);
    lookup(32'h100, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sat_recover: got %0b expected 1", bus.pred_taken_o);
    end
  endtask

  task automatic test_jal_hold;
    lookup(32'h200, enc_j(21'h1FFFF8));
    n_checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_addr_o !== 32'h1F8) begin
      n_fail++; $display("[TB] FAIL jal_pred: got %0b/%h expected 1/000001f8", bus.pred_taken_o, bus.pred_addr_o);
    end
    lookup(32'h300, enc_j(21'h000400));
    n_checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_addr_o !== 32'h700) begin
      n_fail++; $display("[TB] FAIL jal_fwd: got %0b/%h expected 1/00000700", bus.pred_taken_o, bus.pred_addr_o);
    end
    bus.hold_i = 1'b1;
    lookup(32'h200, enc_j(21'h1FFFF8));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0 || bus.pred_addr_o !== 32'h0) begin
      n_fail++; $display("[TB] FAIL jal_hold: got %0b/%h expected 0/00000000", bus.pred_taken_o, bus.pred_addr_o);
    end
    bus.hold_i = 1'b0;
    lookup(32'h100, INST_ADDI);
    n_checks++;
    if (bus.pred_taken_o !== 1'b0 || bus.pred_addr_o !== 32'h0) begin
      n_fail++; $display("[TB] FAIL other_opcode: got %0b/%h expected 0/00000000", bus.pred_taken_o, bus.pred_addr_o);
    end
  endtask

  task automatic test_jalr_alias;
    do_update(2'b10, 32'h40, 1'b1, 32'h8000, 1'b1);
    lookup(32'h40, INST_JALR);
    n_checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_addr_o !== 32'h8000) begin
      n_fail++; $display("[TB] FAIL jalr_hit: got %0b/%h expected 1/00008000", bus.pred_taken_o, bus.pred_addr_o);
    end
    lookup(32'h80, INST_JALR);
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL jalr_other_tag: got %0b expected 0", bus.pred_taken_o);
    end
    // 0x40 and 0x100 share index 0, so the JALR allocation evicted the branch.
    lookup(32'h100, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL alias_evict: got %0b expected 0", bus.pred_taken_o);
    end
    // A JALR allocation leaves the counter weak-taken.
    lookup(32'h40, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_addr_o !== 32'h50) begin
      n_fail++; $display("[TB] FAIL jalr_alloc_cnt: got %0b/%h expected 1/00000050", bus.pred_taken_o, bus.pred_addr_o);
    end
    do_update(2'b10, 32'h40, 1'b1, 32'h9004, 1'b0);
    lookup(32'h40, INST_JALR);
    n_checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_addr_o !== 32'h9004) begin
      n_fail++; $display("[TB] FAIL jalr_retarget: got %0b/%h expected 1/00009004", bus.pred_taken_o, bus.pred_addr_o);
    end
  endtask

  task automatic test_back_to_back;
    lookup(32'h104, enc_b(13'd16));
    bus.upd_valid_i  = 1'b1;
    bus.upd_kind_i   = 2'b01;
    bus.upd_pc_i     = 32'h104;
    bus.upd_taken_i  = 1'b1;
    bus.upd_target_i = 32'h114;
    #1;
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL same_cycle_old: got %0b expected 0", bus.pred_taken_o);
    end
    @(posedge clk);
    #1;
    bus.upd_valid_i = 1'b0;
    #1;
    n_checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_addr_o !== 32'h114) begin
      n_fail++; $display("[TB] FAIL same_cycle_new: got %0b/%h expected 1/00000114", bus.pred_taken_o, bus.pred_addr_o);
    end
  endtask

  task automatic test_perf_reset;
    lookup(32'h0, INST_NOP);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    // Re-train 0x104 so the later reset has something to clear.
    @(negedge clk);
    do_update(2'b01, 32'h104, 1'b1, 32'h114, 1'b0);
    @(negedge clk);
    lookup(32'h200, enc_j(21'h1FFFF8));
    repeat (3) @(posedge clk);
    #1;
    bus.hold_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.hold_i = 1'b0;
    lookup(32'h0, INST_NOP);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.perf_lookups_o !== 32'd3) begin
      n_fail++; $display("[TB] FAIL perf_lookups: got %0d expected 3", bus.perf_lookups_o);
    end
    do_update(2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
    bus.upd_mispred_i = 1'b1;
    @(posedge clk);
    #1;
    bus.upd_mispred_i = 1'b0;
    do_update(2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
    do_update(2'b11, 32'h0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (bus.perf_mispred_o !== 32'd2) begin
      n_fail++; $display("[TB] FAIL perf_mispred: got %0d expected 2", bus.perf_mispred_o);
    end
    // Assert reset mid-cycle with an update pending and a JAL on the lookup port.
    lookup(32'h200, enc_j(21'h1FFFF8));
    bus.upd_valid_i  = 1'b1;
    bus.upd_kind_i   = 2'b01;
    bus.upd_pc_i     = 32'h108;
    bus.upd_taken_i  = 1'b1;
    bus.upd_target_i = 32'h118;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.pred_taken_o !== 1'b0 || bus.pred_addr_o !== 32'h0) begin
      n_fail++; $display("[TB] FAIL rst_mid_pred: got %0b/%h expected 0/00000000", bus.pred_taken_o, bus.pred_addr_o);
    end
    n_checks++;
    if (bus.perf_lookups_o !== 32'h0 || bus.perf_mispred_o !== 32'h0) begin
      n_fail++; $display("[TB] FAIL rst_mid_perf: got %h/%h expected 0/0", bus.perf_lookups_o, bus.perf_mispred_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.upd_valid_i = 1'b0;
    lookup(32'h108, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_pending_discard: got %0b expected 0", bus.pred_taken_o);
    end
    lookup(32'h104, enc_b(13'd16));
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_table_clear: got %0b expected 0", bus.pred_taken_o);
    end
    lookup(32'h200, enc_j(21'h1FFFF8));
    n_checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_addr_o !== 32'h1F8) begin
      n_fail++; $display("[TB] FAIL post_rst_jal: got %0b/%h expected 1/000001f8", bus.pred_taken_o, bus.pred_addr_o);
    end
  endtask

  // Scenario sequence; later tasks rely on the table state left by earlier ones.
  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst               = 1'b1;
    bus.hold_i        = 1'b0;
    bus.lookup_addr_i = '0;
    bus.lookup_inst_i = INST_NOP;
    bus.upd_valid_i   = 1'b0;
    bus.upd_kind_i    = 2'b00;
    bus.upd_pc_i      = '0;
    bus.upd_taken_i   = 1'b0;
    bus.upd_target_i  = '0;
    bus.upd_mispred_i = 1'b0;

    test_reset();
    test_bht_basic();
    test_saturation();
    test_jal_hold();
    test_jalr_alias();
    test_back_to_back();
    test_perf_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
